// File: rtl/rtc_display_mux.sv
// Seven-segment scan driver: snapshots the six clock-core digit codes once per frame
// and drives them one slot at a time with blanking, colon and blink masking.
module rtc_display_mux #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Sec_L,
  input  logic [6:0] Sec_M,
  input  logic [6:0] Min_L,
  input  logic [6:0] Min_M,
  input  logic [6:0] Hour_L,
  input  logic [6:0] Hour_M,
  input  logic       colon_en,
  input  logic [5:0] blink_mask,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [5:0] dig_en,
  output logic       frame_start
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [FRM_W-1:0] FRM_MAX   = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [FRM_W-1:0] frm_cnt, frm_nxt;
  logic             blink_phase, phase_nxt;

  logic [5:0][6:0]  sh_seg, cur_seg;
  logic             sh_colon, cur_colon;
  logic [5:0]       sh_mask, cur_mask;
  logic             sh_phase, cur_phase;

  logic             snap_c, blank_c, sup_c;
  logic [5:0]       sel_c;
  logic [6:0]       live_c;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic [5:0]       dig_nxt;

  assign snap_c = (idx == 3'd0) && (cnt == '0);

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign blank_c = 1'b0;
    end else begin : g_blank
      assign blank_c = (cnt < BLANK_LIM);
    end
  endgenerate

  // Slot timing, frame counter and blink phase
  always_comb begin
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = idx;
    frm_nxt   = frm_cnt;
    phase_nxt = blink_phase;
    if (cnt == CNT_MAX) begin
      cnt_nxt = '0;
      idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
    if (snap_c) begin
      if (frm_cnt == FRM_MAX) begin
        frm_nxt   = '0;
        phase_nxt = ~blink_phase;
      end else begin
        frm_nxt = frm_cnt + FRM_W'(1);
      end
    end
  end

  // On the snapshot edge itself the freshly sampled values are what the slot shows
  always_comb begin
    cur_seg   = snap_c ? {Hour_M, Hour_L, Min_M, Min_L, Sec_M, Sec_L} : sh_seg;
    cur_colon = snap_c ? colon_en    : sh_colon;
    cur_mask  = snap_c ? blink_mask  : sh_mask;
    cur_phase = snap_c ? blink_phase : sh_phase;
    sel_c     = 6'b00_0001 << idx;
    live_c    = '0;
    for (int i = 0; i < 6; i++) begin
      if (sel_c[i]) live_c = cur_seg[i];
    end
    sup_c   = cur_phase && ((cur_mask & sel_c) != 6'b0);
    seg_nxt = '0;
    dp_nxt  = 1'b0;
    dig_nxt = '0;
    if (!blank_c) begin
      dig_nxt = sel_c;
      seg_nxt = sup_c ? 7'b0 : live_c;
      dp_nxt  = cur_colon && ((idx == 3'd2) || (idx == 3'd4)) && !sup_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
      sh_seg      <= '0;
      sh_colon    <= 1'b0;
      sh_mask     <= '0;
      sh_phase    <= 1'b0;
      seg_out     <= '0;
      dp_out      <= 1'b0;
      dig_en      <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      frm_cnt     <= frm_nxt;
      blink_phase <= phase_nxt;
      // Shadow phase lags the toggle by one frame so each phase lasts BLINK_FRAMES frames
      if (snap_c) begin
        sh_seg   <= {Hour_M, Hour_L, Min_M, Min_L, Sec_M, Sec_L};
        sh_colon <= colon_en;
        sh_mask  <= blink_mask;
        sh_phase <= blink_phase;
      end
      seg_out     <= seg_nxt;
      dp_out      <= dp_nxt;
      dig_en      <= dig_nxt;
      frame_start <= snap_c;
    end
  end

endmodule

// File: tb/tb_rtc_display_mux.sv
// Randomized bench for rtc_display_mux against a frame/slot arithmetic reference model.
module tb_rtc_display_mux;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Sec_L, Sec_M, Min_L, Min_M, Hour_L, Hour_M;
  logic       colon_en;
  logic [5:0] blink_mask;

  logic [6:0] seg_out, seg_out_z;
  logic       dp_out, dp_out_z;
  logic [5:0] dig_en, dig_en_z;
  logic       frame_start, frame_start_z;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rtc_display_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst),
    .Sec_L(Sec_L), .Sec_M(Sec_M), .Min_L(Min_L), .Min_M(Min_M),
    .Hour_L(Hour_L), .Hour_M(Hour_M),
    .colon_en(colon_en), .blink_mask(blink_mask),
    .seg_out(seg_out), .dp_out(dp_out), .dig_en(dig_en), .frame_start(frame_start)
  );

  rtc_display_mux #(.SCAN_DIV(SD), .BLANK_CYC(0), .BLINK_FRAMES(BF)) dut_z (
    .clk(clk), .rst(rst),
    .Sec_L(Sec_L), .Sec_M(Sec_M), .Min_L(Min_L), .Min_M(Min_M),
    .Hour_L(Hour_L), .Hour_M(Hour_M),
    .colon_en(colon_en), .blink_mask(blink_mask),
    .seg_out(seg_out_z), .dp_out(dp_out_z), .dig_en(dig_en_z), .frame_start(frame_start_z)
  );

  // Reference: edge count since reset and the inputs captured at each frame start
  int         n;
  logic [6:0] m_seg [6];
  logic       m_colon;
  logic [5:0] m_mask;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0;
    end else begin
      n = n + 1;
      if ((n - 1) % FRAME == 0) begin
        m_seg[0] = Sec_L;  m_seg[1] = Sec_M;  m_seg[2] = Min_L;
        m_seg[3] = Min_M;  m_seg[4] = Hour_L; m_seg[5] = Hour_M;
        m_colon  = colon_en;
        m_mask   = blink_mask;
      end
    end
  end

  // Expected {dig_en, seg_out, dp_out, frame_start} after edge nn
  function automatic logic [14:0] model(input int nn, input int bc);
    int s, c, d, fr;
    logic sup;
    logic [5:0] e_dig;
    logic [6:0] e_seg;
    logic e_dp, e_fs;
    e_dig = '0; e_seg = '0; e_dp = 1'b0; e_fs = 1'b0;
    if (nn > 0) begin
      s  = nn - 1;
      c  = s % SD;
      d  = (s / SD) % 6;
      fr = s / FRAME;
      e_fs = (c == 0) && (d == 0);
      if (c >= bc) begin
        sup   = (((fr / BF) % 2) == 1) && m_mask[d];
        e_dig = 6'(1 << d);
        e_seg = sup ? 7'h00 : m_seg[d];
        e_dp  = m_colon && (d == 2 || d == 4) && !sup;
      end
    end
    return {e_dig, e_seg, e_dp, e_fs};
  endfunction

  task automatic rand_digits();
    Sec_L  = 7'($urandom_range(1, 127)); Sec_M  = 7'($urandom_range(1, 127));
    Min_L  = 7'($urandom_range(1, 127)); Min_M  = 7'($urandom_range(1, 127));
    Hour_L = 7'($urandom_range(1, 127)); Hour_M = 7'($urandom_range(1, 127));
  endtask

  task automatic restart();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    rand_digits();
    colon_en = 1'b0; blink_mask = 6'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({dig_en, seg_out, dp_out, frame_start} !== 15'h0)
      $display("FAIL reset_outputs got=%h exp=0", {dig_en, seg_out, dp_out, frame_start});
    else passed++;
    total++;
    if ({dig_en_z, seg_out_z, dp_out_z, frame_start_z} !== 15'h0)
      $display("FAIL reset_outputs_z got=%h exp=0", {dig_en_z, seg_out_z, dp_out_z, frame_start_z});
    else passed++;
    rst = 1'b0;
    for (int k = 0; k < 56; k++) begin
      @(negedge clk);
      exp = model(n, BC);
      total++;
      if ({dig_en, seg_out, dp_out, frame_start} !== exp)
        $display("FAIL scan_order n=%0d got=%h exp=%h", n, {dig_en, seg_out, dp_out, frame_start}, exp);
      else passed++;
      if (n == 2 || n == 5 || n == 10 || n == 45 || n == 51) begin
        total++;
        if (dig_en !== ((n == 2 || n == 10) ? 6'b0 : (n == 45) ? 6'b100000 : 6'b000001))
          $display("FAIL scan_slot n=%0d got=%b", n, dig_en);
        else passed++;
      end
    end
  endtask

  task automatic test_snapshot();
    logic [14:0] exp;
    rand_digits();
    Min_L = 7'h06; colon_en = 1'b0; blink_mask = 6'b0;
    restart();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      exp = model(n, BC);
      total++;
      if ({dig_en, seg_out, dp_out, frame_start} !== exp)
        $display("FAIL snapshot n=%0d got=%h exp=%h", n, {dig_en, seg_out, dp_out, frame_start}, exp);
      else passed++;
      if (n == 20 || n == 70) begin
        total++;
        if (dig_en !== 6'b000100 || seg_out !== ((n == 20) ? 7'h06 : 7'h5B))
          $display("FAIL snapshot_min_l n=%0d got=%h dig=%b", n, seg_out, dig_en);
        else passed++;
      end
      if (n == 1 || n == 48 || n == 49) begin
        total++;
        if (frame_start !== (n != 48))
          $display("FAIL frame_start n=%0d got=%b", n, frame_start);
        else passed++;
      end
      if (n == 19) Min_L = 7'h5B;
      Sec_L = 7'($urandom); Hour_M = 7'($urandom); Min_M = 7'($urandom);
    end
  endtask

  task automatic test_colon();
    logic [14:0] exp;
    rand_digits();
    colon_en = 1'b1; blink_mask = 6'b0;
    restart();
    for (int k = 0; k < 96; k++) begin
      @(negedge clk);
      exp = model(n, BC);
      total++;
      if ({dig_en, seg_out, dp_out, frame_start} !== exp)
        $display("FAIL colon n=%0d got=%h exp=%h", n, {dig_en, seg_out, dp_out, frame_start}, exp);
      else passed++;
      total++;
      if (dp_out !== (dig_en == 6'b000100 || dig_en == 6'b010000))
        $display("FAIL colon_slot n=%0d dp=%b dig=%b", n, dp_out, dig_en);
      else passed++;
    end
  endtask

  task automatic test_blink();
    logic [14:0] exp;
    int fr;
    rand_digits();
    colon_en = 1'b1; blink_mask = 6'b110000;
    restart();
    for (int k = 0; k < 6 * FRAME; k++) begin
      @(negedge clk);
      exp = model(n, BC);
      fr  = (n - 1) / FRAME;
      total++;
      if ({dig_en, seg_out, dp_out, frame_start} !== exp)
        $display("FAIL blink n=%0d got=%h exp=%h", n, {dig_en, seg_out, dp_out, frame_start}, exp);
      else passed++;
      if (dig_en[5:4] != 2'b00) begin
        total++;
        if ((fr == 2 || fr == 3) ? ({seg_out, dp_out} !== 8'h00) : (seg_out === 7'h00))
          $display("FAIL blink_hours frame=%0d seg=%h dp=%b", fr, seg_out, dp_out);
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] exp;
    rand_digits();
    colon_en = 1'b1; blink_mask = 6'($urandom);
    restart();
    while (n < 28) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({dig_en, seg_out, dp_out, frame_start} !== 15'h0)
      $display("FAIL async_reset got=%h exp=0", {dig_en, seg_out, dp_out, frame_start});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 56; k++) begin
      @(negedge clk);
      exp = model(n, BC);
      total++;
      if ({dig_en, seg_out, dp_out, frame_start} !== exp)
        $display("FAIL after_reset n=%0d got=%h exp=%h", n, {dig_en, seg_out, dp_out, frame_start}, exp);
      else passed++;
    end
  endtask

  task automatic test_no_blank();
    logic [14:0] exp, exp_z;
    rand_digits();
    colon_en = 1'b1; blink_mask = 6'($urandom);
    restart();
    for (int k = 0; k < 4 * FRAME; k++) begin
      @(negedge clk);
      exp   = model(n, BC);
      exp_z = model(n, 0);
      total++;
      if ({dig_en, seg_out, dp_out, frame_start} !== exp)
        $display("FAIL random n=%0d got=%h exp=%h", n, {dig_en, seg_out, dp_out, frame_start}, exp);
      else passed++;
      total++;
      if ({dig_en_z, seg_out_z, dp_out_z, frame_start_z} !== exp_z)
        $display("FAIL no_blank n=%0d got=%h exp=%h", n, {dig_en_z, seg_out_z, dp_out_z, frame_start_z}, exp_z);
      else passed++;
      total++;
      if (!$onehot(dig_en_z))
        $display("FAIL no_blank_onehot n=%0d got=%b exp=onehot", n, dig_en_z);
      else passed++;
      rand_digits();
      colon_en   = 1'($urandom);
      blink_mask = 6'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_snapshot();
    test_colon();
    test_blink();
    test_async_reset();
    test_no_blank();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
